// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide sequencer.
// Optional build macro used by ex_muldiv_ctrl: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_e;

    // Divide ops share the upper encoding bit.
    function automatic logic op_is_div(input muldiv_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// Pipeline <-> mul/div sequencer handshake bundle.
// master: EX pipeline side, slave: ex_muldiv_ctrl.
interface ex_muldiv_ctrl_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            stall;

    modport master (
        output start, op, A, B, flush,
        input  busy, done, result, stall
    );

    modport slave (
        input  start, op, A, B, flush,
        output busy, done, result, stall
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared mul/div datapath.
// work = {hi, lo}: multiply keeps the running product, divide keeps
// {remainder, quotient}.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                    is_div,
    input  logic [$clog2(XLEN)-1:0] cnt,
    input  logic [XLEN-1:0]         opa,
    input  logic [XLEN-1:0]         opb,
    input  logic [2*XLEN-1:0]       work_in,
    output logic [2*XLEN-1:0]       work_out
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] hi, lo;
    logic [XLEN:0]   msum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [CW-1:0]   didx;
    logic            qbit;
    logic [XLEN-1:0] new_hi;

    assign hi   = work_in[2*XLEN-1:XLEN];
    assign lo   = work_in[XLEN-1:0];
    assign didx = CW'(XLEN-1) - cnt;

    // Multiply: add multiplicand on multiplier bit cnt, shift product right.
    // Divide: shift in dividend bit (MSB first), trial subtract, restore on borrow.
    always_comb begin
        msum   = {1'b0, hi} + (opb[cnt] ? {1'b0, opa} : '0);
        rem_sh = {hi, opa[didx]};
        diff   = rem_sh - {1'b0, opb};
        qbit   = ~diff[XLEN];
        new_hi = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        if (is_div)
            work_out = {new_hi, lo[XLEN-2:0], qbit};
        else
            work_out = {msum, lo[XLEN-1:1]};
    end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage iterative sequencer for MUL/MULHU/DIVU/REMU (unsigned).
// XLEN iterations per op, registered result, pipeline stall while busy.
// Build macro: MULDIV_EARLY_OUT_EN -- B==0 skips RUN and completes in one cycle.
module ex_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_ITER
) (
    input  logic clk,
    input  logic reset,
    ex_muldiv_ctrl_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    muldiv_state_e   state;
    muldiv_op_e      op_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] a_q, b_q;
    logic [2*XLEN-1:0] work, work_nxt;
    logic [XLEN-1:0] result_q, res_sel;
    logic            busy_q, done_q;
    logic            accept;

    assign accept     = bus.start & ~bus.flush & (state != ST_RUN);
    // A start accepted from DONE lets the pipeline advance; from IDLE it stalls.
    assign bus.stall  = accept ? (state != ST_DONE) : busy_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (op_is_div(op_q)),
        .cnt      (cnt),
        .opa      (a_q),
        .opb      (b_q),
        .work_in  (work),
        .work_out (work_nxt)
    );

    // Select final result from the last iteration's working register.
    always_comb begin
        res_sel = '0;
        case (op_q)
            OP_MUL:   res_sel = work_nxt[XLEN-1:0];
            OP_MULHU: res_sel = work_nxt[2*XLEN-1:XLEN];
            OP_DIVU:  res_sel = work_nxt[XLEN-1:0];
            OP_REMU:  res_sel = work_nxt[2*XLEN-1:XLEN];
            default:  res_sel = '0;
        endcase
    end

    // Sequencer FSM, iteration counter, operand/working/result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            op_q <= muldiv_op_e'(bus.op);
                            a_q  <= bus.A;
                            b_q  <= bus.B;
                            work <= '0;
                            cnt  <= '0;
`ifdef MULDIV_EARLY_OUT_EN
                            if (bus.B == '0) begin
                                state  <= ST_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                case (muldiv_op_e'(bus.op))
                                    OP_DIVU: result_q <= '1;
                                    OP_REMU: result_q <= bus.A;
                                    default: result_q <= '0;
                                endcase
                            end else begin
                                state  <= ST_RUN;
                                busy_q <= 1'b1;
                            end
`else
                            state  <= ST_RUN;
                            busy_q <= 1'b1;
`endif
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        work <= work_nxt;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(XLEN-1)) begin
                            state    <= ST_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= res_sel;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl (honours MULDIV_EARLY_OUT_EN).
module tb_ex_muldiv_ctrl;
    logic clk = 1'b0;
    logic reset;
    int unsigned tests = 0;
    int unsigned fails = 0;

    ex_muldiv_ctrl_if #(.XLEN(32)) bus ();

    ex_muldiv_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Abstract reference: plain 64-bit arithmetic, RISC-V divide-by-zero rules.
    function automatic logic [31:0] ref_model(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (b == 0) return 1;
`endif
        return 33;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (possibly from the DONE cycle) and wait for its done cycle.
    // Leaves the bench sitting in the DONE cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic from_done;
        int cyc;
        int low_stall;
        from_done = bus.done;
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        #1;
        check({tag, "_stall_start"}, 32'(bus.stall), from_done ? 32'd0 : 32'd1);
        tick();
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
        cyc = 1;
        low_stall = 0;
        while (!bus.done && cyc < 100) begin
            if (!bus.stall) low_stall++;
            tick();
            cyc++;
        end
        check({tag, "_done"},     32'(bus.done), 32'd1);
        check({tag, "_latency"},  32'(cyc), 32'(exp_latency(b)));
        check({tag, "_stall_run"}, 32'(low_stall), 32'd0);
        check({tag, "_result"},   bus.result, ref_model(op, a, b));
        check({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
        check({tag, "_busy_done"},  32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev, a, b;
        logic [1:0]  op;
        int cyc, dcount;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'd0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) tick();
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_done",   32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_stall",  32'(bus.stall), 32'd0);
        reset = 1'b0;
        tick();

        // Directed ops with constant expectations
        run_op(2'd0, 32'd7, 32'd6, "mul7x6");
        check("mul7x6_const", bus.result, 32'd42);
        tick();
        check("done_one_cycle", 32'(bus.done), 32'd0);

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        check("mulhu_max_const", bus.result, 32'hFFFF_FFFE);
        tick();
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
        check("mul_max_const", bus.result, 32'h0000_0001);
        tick();

        run_op(2'd2, 32'd100, 32'd7, "divu100_7");
        check("divu_const", bus.result, 32'd14);
        run_op(2'd3, 32'd100, 32'd7, "remu_b2b");
        check("remu_const", bus.result, 32'd2);
        tick();

        run_op(2'd2, 32'h1234, 32'd0, "divu_by0");
        check("divu_by0_const", bus.result, 32'hFFFF_FFFF);
        tick();
        run_op(2'd3, 32'h1234, 32'd0, "remu_by0");
        check("remu_by0_const", bus.result, 32'h0000_1234);
        tick();

        // Randomized ops, mixing back-to-back issue and idle gaps
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_op(op, a, b, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();

        // Flush at cnt==10
        prev = bus.result;
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.A     = $urandom;
        bus.B     = $urandom | 32'd1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        check("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy",  32'(bus.busy), 32'd0);
        check("flush_stall", 32'(bus.stall), 32'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dcount++;
            tick();
        end
        check("flush_no_done", 32'(dcount), 32'd0);
        check("flush_result_held", bus.result, prev);

        // start and flush together: flush wins
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 2'd2;
        bus.A     = 32'd50;
        bus.B     = 32'd0;
        #1;
        check("startflush_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("startflush_busy", 32'(bus.busy), 32'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dcount++;
            tick();
        end
        check("startflush_no_done", 32'(dcount), 32'd0);
        check("startflush_result", bus.result, prev);

        // Asynchronous reset mid-RUN
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.A     = 32'd3;
        bus.B     = 32'd5;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy",   32'(bus.busy), 32'd0);
        check("arst_done",   32'(bus.done), 32'd0);
        check("arst_result", bus.result, 32'd0);
        check("arst_stall",  32'(bus.stall), 32'd0);
        #1;
        reset = 1'b0;
        tick();

        // start pulses during RUN must be ignored
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.A     = 32'd1000;
        bus.B     = 32'd3;
        tick();
        cyc = 1;
        while (!bus.done && cyc < 100) begin
            bus.start = (cyc % 4 == 0);
            bus.op    = 2'd0;
            bus.A     = $urandom;
            bus.B     = $urandom;
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        check("ignore_latency", 32'(cyc), 32'd33);
        check("ignore_result", bus.result, 32'd333);
        tick();
        check("ignore_idle_busy", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
